// File: rtl/load_sequencer.sv
// Serial payload loader: packs UART bits into bytes for the image, coef and
// bias stores, then hands off to the CNN core and waits for completion.
module load_sequencer #(
  parameter int IMG_BITS  = 3136,
  parameter int COEF_BITS = 138880,
  parameter int BIAS_BITS = 424,
  parameter int ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              bit_i,
  input  logic              bit_valid_i,
  input  logic              cnn_done_i,
  output logic              wr_en_o,
  output logic [1:0]        wr_sel_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              cnn_start_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int MAX_IC =
    (IMG_BITS > COEF_BITS) ? IMG_BITS : COEF_BITS;
  localparam int MAX_BITS =
    (MAX_IC > BIAS_BITS) ? MAX_IC : BIAS_BITS;
  localparam int CNT_W = $clog2(MAX_BITS);

  localparam logic [CNT_W-1:0] IMG_LAST =
    CNT_W'(IMG_BITS - 1);
  localparam logic [CNT_W-1:0] COEF_LAST =
    CNT_W'(COEF_BITS - 1);
  localparam logic [CNT_W-1:0] BIAS_LAST =
    CNT_W'(BIAS_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IMG,
    LOAD_COEF,
    LOAD_BIAS,
    START,
    RUN,
    DONE
  } state_t;

  state_t            state;
  state_t            load_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        byte_buf;
  logic [ADDR_W-1:0] word_addr;
  logic              is_load;
  logic              phase_last;
  logic [1:0]        phase_sel;
  logic [7:0]        byte_next;

  // LSB-first: each new bit enters at the top and slides down.
  assign byte_next = {bit_i, byte_buf[7:1]};

  always_comb begin
    is_load    = 1'b0;
    phase_last = 1'b0;
    phase_sel  = 2'd0;
    load_next  = IDLE;
    unique case (1'b1)
      (state == LOAD_IMG): begin
        is_load    = 1'b1;
        phase_last = (bit_cnt == IMG_LAST);
        phase_sel  = 2'd0;
        load_next  = LOAD_COEF;
      end
      (state == LOAD_COEF): begin
        is_load    = 1'b1;
        phase_last = (bit_cnt == COEF_LAST);
        phase_sel  = 2'd1;
        load_next  = LOAD_BIAS;
      end
      (state == LOAD_BIAS): begin
        is_load    = 1'b1;
        phase_last = (bit_cnt == BIAS_LAST);
        phase_sel  = 2'd2;
        load_next  = START;
      end
      default: begin
        is_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      byte_buf    <= '0;
      word_addr   <= '0;
      wr_en_o     <= 1'b0;
      wr_sel_o    <= 2'd0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      cnn_start_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      wr_en_o     <= 1'b0;
      cnn_start_o <= 1'b0;
      done_o      <= 1'b0;
      if (bit_valid_i && !is_load)
        err_o <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state     <= LOAD_IMG;
            busy_o    <= 1'b1;
            err_o     <= 1'b0;
            bit_cnt   <= '0;
            word_addr <= '0;
          end
        end
        LOAD_IMG, LOAD_COEF, LOAD_BIAS: begin
          if (bit_valid_i) begin
            byte_buf <= byte_next;
            if (bit_cnt[2:0] == 3'd7) begin
              wr_en_o   <= 1'b1;
              wr_sel_o  <= phase_sel;
              wr_addr_o <= word_addr;
              wr_data_o <= byte_next;
              word_addr <= word_addr + 1'b1;
            end
            // Clearing here overrides the increment above on the last word.
            if (phase_last) begin
              bit_cnt     <= '0;
              word_addr   <= '0;
              state       <= load_next;
              cnn_start_o <= (load_next == START);
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          if (cnn_done_i) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
